alu16b_sched: RTL and testbench



---
 rtl/alu16b_sched_if.sv | 53 +++++
 rtl/alu16b_sched.sv | 117 +++++++++++
 tb/tb_alu16b_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu16b_sched_if.sv
// Request, response and shared-ALU signals of the two-port ALU scheduler.
// slave faces the scheduler; master faces requesters and the ALU.
interface alu16b_sched_if;
   logic        req0_valid;
   logic        req1_valid;
   logic        req0_ready;
   logic        req1_ready;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic [1:0]  req0_op;
   logic [1:0]  req1_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [1:0]  alu_sel;
   logic [15:0] alu_out;
   logic        alu_ov;
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic        rsp0_ready;
   logic        rsp1_ready;
   logic [15:0] rsp_data;
   logic        rsp_ov;
   logic        rsp_err;
   logic        busy;

   modport slave (
      input  req0_valid, req1_valid,
      input  req0_a, req0_b, req1_a, req1_b,
      input  req0_op, req1_op,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_sel,
      input  alu_out, alu_ov,
      output rsp0_valid, rsp1_valid,
      input  rsp0_ready, rsp1_ready,
      output rsp_data, rsp_ov, rsp_err,
      output busy
   );

   modport master (
      output req0_valid, req1_valid,
      output req0_a, req0_b, req1_a, req1_b,
      output req0_op, req1_op,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_sel,
      output alu_out, alu_ov,
      input  rsp0_valid, rsp1_valid,
      output rsp0_ready, rsp1_ready,
      input  rsp_data, rsp_ov, rsp_err,
      input  busy
   );
endinterface

// File: rtl/alu16b_sched.sv
// Round-robin scheduler sharing one 16-bit ALU between two requesters.
// Div-by-zero is answered directly without occupying the ALU.
module alu16b_sched #(
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   alu16b_sched_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);

   state_t      state_q;
   state_t      state_d;
   logic [3:0]  cnt_q;
   logic        last_q;
   logic        port_q;
   logic [15:0] alu_a_q;
   logic [15:0] alu_b_q;
   logic [1:0]  alu_sel_q;
   logic [15:0] rsp_data_q;
   logic        rsp_ov_q;
   logic        rsp_err_q;

   logic        grant0;
   logic        grant1;
   logic        accept;
   logic [15:0] a_w;
   logic [15:0] b_w;
   logic [1:0]  op_w;
   logic        div0;
   logic        exec_last;
   logic        rsp_hs;

   // last_q = 0 means port 0 was served last, so port 1 wins a tie
   always_comb begin
      grant1    = bus.req1_valid && (!bus.req0_valid || !last_q);
      grant0    = bus.req0_valid && !grant1;
      accept    = (state_q == IDLE) && (grant0 || grant1);
      a_w       = grant1 ? bus.req1_a  : bus.req0_a;
      b_w       = grant1 ? bus.req1_b  : bus.req0_b;
      op_w      = grant1 ? bus.req1_op : bus.req0_op;
      div0      = (op_w == 2'b11) && (b_w == 16'h0000);
      exec_last = (state_q == EXEC) && (cnt_q == LAST);
      rsp_hs    = (state_q == RESP) &&
                  (port_q ? bus.rsp1_ready : bus.rsp0_ready);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = div0 ? RESP : EXEC;
         EXEC: if (exec_last) state_d = RESP;
         RESP: if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= 4'd0;
         last_q     <= 1'b1;
         port_q     <= 1'b0;
         alu_a_q    <= 16'h0000;
         alu_b_q    <= 16'h0000;
         alu_sel_q  <= 2'b00;
         rsp_data_q <= 16'h0000;
         rsp_ov_q   <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q     <= 4'd0;
            last_q    <= grant1;
            port_q    <= grant1;
            alu_a_q   <= a_w;
            alu_b_q   <= b_w;
            alu_sel_q <= op_w;
            if (div0) begin
               rsp_data_q <= 16'hFFFF;
               rsp_ov_q   <= 1'b1;
               rsp_err_q  <= 1'b1;
            end
         end
         if (state_q == EXEC && !exec_last)
            cnt_q <= cnt_q + 4'd1;
         if (exec_last) begin
            rsp_data_q <= bus.alu_out;
            rsp_ov_q   <= bus.alu_ov;
            rsp_err_q  <= 1'b0;
         end
      end
   end

   assign bus.req0_ready = (state_q == IDLE) && grant0;
   assign bus.req1_ready = (state_q == IDLE) && grant1;
   assign bus.rsp0_valid = (state_q == RESP) && !port_q;
   assign bus.rsp1_valid = (state_q == RESP) && port_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_sel    = alu_sel_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_ov     = rsp_ov_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu16b_sched.sv
// Directed bench for alu16b_sched with a behavioural 16-bit ALU.
// One instance runs EXEC_CYCLES=1, a second EXEC_CYCLES=4.
module tb_alu16b_sched;

   logic clk = 1'b0;
   logic rst_n;
   logic rst4_n;
   int   checks = 0;
   int   failures = 0;

   alu16b_sched_if ifa();
   alu16b_sched_if ifb();

   alu16b_sched #(.EXEC_CYCLES(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.slave)
   );

   alu16b_sched #(.EXEC_CYCLES(4)) dut4 (
      .clk   (clk),
      .rst_n (rst4_n),
      .bus   (ifb.slave)
   );

   function automatic logic [16:0] alu_f(logic [15:0] a, logic [15:0] b,
                                         logic [1:0] s);
      logic [31:0] p;
      logic [16:0] r;
      p = 32'(a) * 32'(b);
      r = 17'd0;
      case (s)
         2'b00: r = {1'b0, a} + {1'b0, b};
         2'b01: r = {a < b, a - b};
         2'b10: r = {|p[31:16], p[15:0]};
         default: r = {1'b0, (b == 16'h0) ? 16'hFFFF : a / b};
      endcase
      return r;
   endfunction

   assign {ifa.alu_ov, ifa.alu_out} = alu_f(ifa.alu_a, ifa.alu_b, ifa.alu_sel);
   assign {ifb.alu_ov, ifb.alu_out} = alu_f(ifb.alu_a, ifb.alu_b, ifb.alu_sel);

   always #5 clk = ~clk;

   task automatic idle_inputs();
      ifa.req0_valid = 0; ifa.req1_valid = 0;
      ifa.req0_a = 0; ifa.req0_b = 0; ifa.req0_op = 0;
      ifa.req1_a = 0; ifa.req1_b = 0; ifa.req1_op = 0;
      ifa.rsp0_ready = 0; ifa.rsp1_ready = 0;
      ifb.req0_valid = 0; ifb.req1_valid = 0;
      ifb.req0_a = 0; ifb.req0_b = 0; ifb.req0_op = 0;
      ifb.req1_a = 0; ifb.req1_b = 0; ifb.req1_op = 0;
      ifb.rsp0_ready = 0; ifb.rsp1_ready = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      rst4_n = 0;
      #1;
      checks++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b00) begin failures++; $display("FAIL rst_req_ready got=%b exp=00", {ifa.req0_ready, ifa.req1_ready}); end
      checks++; if ({ifa.rsp0_valid, ifa.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=00", {ifa.rsp0_valid, ifa.rsp1_valid}); end
      checks++; if ({ifa.alu_a, ifa.alu_b, ifa.alu_sel} !== 34'd0) begin failures++; $display("FAIL rst_alu got=%h/%h/%h exp=0", ifa.alu_a, ifa.alu_b, ifa.alu_sel); end
      checks++; if ({ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err} !== 18'd0) begin failures++; $display("FAIL rst_rsp got=%h/%b/%b exp=0", ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err); end
      checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", ifa.busy); end
      @(negedge clk);
      rst_n = 1;
      rst4_n = 1;
   endtask

   task automatic test_add();
      step();
      ifa.req0_a = 16'h0003; ifa.req0_b = 16'h0004; ifa.req0_op = 2'b00;
      ifa.req0_valid = 1; ifa.rsp0_ready = 1;
      #1;
      checks++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10) begin failures++; $display("FAIL add_grant got=%b exp=10", {ifa.req0_ready, ifa.req1_ready}); end
      step();
      ifa.req0_valid = 0;
      checks++; if ({ifa.busy, ifa.rsp0_valid} !== 2'b10) begin failures++; $display("FAIL add_exec busy/valid got=%b exp=10", {ifa.busy, ifa.rsp0_valid}); end
      checks++; if ({ifa.alu_a, ifa.alu_b} !== {16'h0003, 16'h0004}) begin failures++; $display("FAIL add_alu_ops got=%h/%h exp=0003/0004", ifa.alu_a, ifa.alu_b); end
      step();
      checks++; if ({ifa.rsp0_valid, ifa.rsp1_valid} !== 2'b10) begin failures++; $display("FAIL add_rsp_valid got=%b exp=10", {ifa.rsp0_valid, ifa.rsp1_valid}); end
      checks++; if ({ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err} !== {16'h0007, 2'b00}) begin failures++; $display("FAIL add_payload got=%h/%b/%b exp=0007/0/0", ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err); end
      step();
      checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL add_idle got=%b exp=0", ifa.busy); end
      ifa.rsp0_ready = 0;
   endtask

   task automatic test_mul();
      ifa.req1_a = 16'h0100; ifa.req1_b = 16'h0100; ifa.req1_op = 2'b10;
      ifa.req1_valid = 1; ifa.rsp1_ready = 1;
      #1;
      checks++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b01) begin failures++; $display("FAIL mul_grant got=%b exp=01", {ifa.req0_ready, ifa.req1_ready}); end
      step();
      ifa.req1_valid = 0;
      checks++; if ({ifa.rsp0_valid, ifa.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL mul_exec_valid got=%b exp=00", {ifa.rsp0_valid, ifa.rsp1_valid}); end
      step();
      checks++; if ({ifa.rsp0_valid, ifa.rsp1_valid} !== 2'b01) begin failures++; $display("FAIL mul_rsp_valid got=%b exp=01", {ifa.rsp0_valid, ifa.rsp1_valid}); end
      checks++; if ({ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err} !== {16'h0000, 2'b10}) begin failures++; $display("FAIL mul_payload got=%h/%b/%b exp=0000/1/0", ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err); end
      step();
      ifa.rsp1_ready = 0;
   endtask

   task automatic test_div0();
      ifa.req0_a = 16'h1234; ifa.req0_b = 16'h0000; ifa.req0_op = 2'b11;
      ifa.req0_valid = 1; ifa.rsp0_ready = 1;
      #1;
      checks++; if (ifa.req0_ready !== 1'b1) begin failures++; $display("FAIL div0_grant got=%b exp=1", ifa.req0_ready); end
      step();
      ifa.req0_valid = 0;
      checks++; if ({ifa.busy, ifa.rsp0_valid, ifa.rsp1_valid} !== 3'b110) begin failures++; $display("FAIL div0_rsp_valid got=%b exp=110", {ifa.busy, ifa.rsp0_valid, ifa.rsp1_valid}); end
      checks++; if ({ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err} !== {16'hFFFF, 2'b11}) begin failures++; $display("FAIL div0_payload got=%h/%b/%b exp=FFFF/1/1", ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err); end
      checks++; if ({ifa.alu_a, ifa.alu_sel} !== {16'h1234, 2'b11}) begin failures++; $display("FAIL div0_alu got=%h/%b exp=1234/11", ifa.alu_a, ifa.alu_sel); end
      step();
      checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL div0_idle got=%b exp=0", ifa.busy); end
      ifa.rsp0_ready = 0;
   endtask

   task automatic test_round_robin();
      int exp_g[4] = '{0, 1, 0, 1};
      rst_n = 0;
      #1;
      rst_n = 1;
      step();
      ifa.req0_a = 16'h0001; ifa.req0_b = 16'h0001; ifa.req0_op = 2'b00;
      ifa.req1_a = 16'h0002; ifa.req1_b = 16'h0002; ifa.req1_op = 2'b00;
      ifa.rsp0_ready = 1; ifa.rsp1_ready = 1;
      ifa.req0_valid = 1; ifa.req1_valid = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         int w = 0;
         int g;
         while (!(ifa.req0_ready || ifa.req1_ready) && w < 20) begin
            step();
            w++;
         end
         checks++; if (w >= 20) begin failures++; $display("FAIL rr_timeout op=%0d got=no_grant exp=grant", i); end
         checks++; if (ifa.req0_ready && ifa.req1_ready) begin failures++; $display("FAIL rr_double op=%0d got=11 exp=one", i); end
         g = ifa.req1_ready ? 1 : 0;
         checks++; if (g !== exp_g[i]) begin failures++; $display("FAIL rr_order op=%0d got=%0d exp=%0d", i, g, exp_g[i]); end
         step();
      end
      ifa.req0_valid = 0; ifa.req1_valid = 0;
      repeat (5) step();
      ifa.req0_valid = 1; ifa.req1_valid = 1;
      #1;
      checks++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10) begin failures++; $display("FAIL rr_hold_after1 got=%b exp=10", {ifa.req0_ready, ifa.req1_ready}); end
      step();
      ifa.req0_valid = 0; ifa.req1_valid = 0;
      repeat (5) step();
      ifa.req0_valid = 1; ifa.req1_valid = 1;
      #1;
      checks++; if ({ifa.req0_ready, ifa.req1_ready} !== 2'b01) begin failures++; $display("FAIL rr_hold_after0 got=%b exp=01", {ifa.req0_ready, ifa.req1_ready}); end
      step();
      ifa.req0_valid = 0; ifa.req1_valid = 0;
      repeat (4) step();
      ifa.rsp0_ready = 0; ifa.rsp1_ready = 0;
   endtask

   task automatic test_backpressure();
      ifa.req0_a = 16'h0005; ifa.req0_b = 16'h0006; ifa.req0_op = 2'b00;
      ifa.req0_valid = 1; ifa.rsp0_ready = 0; ifa.rsp1_ready = 1;
      step();
      ifa.req0_valid = 0;
      step();
      ifa.req0_valid = 1; ifa.req1_valid = 1;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++; if ({ifa.rsp0_valid, ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err} !== {1'b1, 16'h000B, 2'b00}) begin failures++; $display("FAIL bp_payload cyc=%0d got=%b/%h/%b/%b exp=1/000B/0/0", i, ifa.rsp0_valid, ifa.rsp_data, ifa.rsp_ov, ifa.rsp_err); end
         checks++; if ({ifa.req0_ready, ifa.req1_ready, ifa.busy} !== 3'b001) begin failures++; $display("FAIL bp_ready_busy cyc=%0d got=%b exp=001", i, {ifa.req0_ready, ifa.req1_ready, ifa.busy}); end
         step();
      end
      ifa.req0_valid = 0;
      ifa.rsp0_ready = 1;
      #1;
      checks++; if (ifa.req1_ready !== 1'b0) begin failures++; $display("FAIL bp_hs_accept got=%b exp=0", ifa.req1_ready); end
      step();
      checks++; if ({ifa.busy, ifa.req1_ready} !== 2'b01) begin failures++; $display("FAIL bp_reaccept got=%b exp=01", {ifa.busy, ifa.req1_ready}); end
      ifa.req1_valid = 0;
      step();
      checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL bp_drop got=%b exp=0", ifa.busy); end
      ifa.rsp0_ready = 0; ifa.rsp1_ready = 0;
   endtask

   task automatic test_exec4();
      ifb.req0_a = 16'h0010; ifb.req0_b = 16'h0020; ifb.req0_op = 2'b00;
      ifb.req0_valid = 1; ifb.rsp0_ready = 1;
      #1;
      checks++; if (ifb.req0_ready !== 1'b1) begin failures++; $display("FAIL ex4_grant got=%b exp=1", ifb.req0_ready); end
      step();
      ifb.req0_valid = 0;
      for (int k = 0; k < 4; k++) begin
         checks++; if ({ifb.busy, ifb.rsp0_valid} !== 2'b10) begin failures++; $display("FAIL ex4_exec k=%0d got=%b exp=10", k, {ifb.busy, ifb.rsp0_valid}); end
         step();
      end
      checks++; if ({ifb.rsp0_valid, ifb.rsp_data, ifb.rsp_err} !== {1'b1, 16'h0030, 1'b0}) begin failures++; $display("FAIL ex4_rsp got=%b/%h/%b exp=1/0030/0", ifb.rsp0_valid, ifb.rsp_data, ifb.rsp_err); end
      step();
      checks++; if (ifb.busy !== 1'b0) begin failures++; $display("FAIL ex4_idle got=%b exp=0", ifb.busy); end
   endtask

   task automatic test_reset_mid_exec();
      int bad = 0;
      ifb.req0_a = 16'h0007; ifb.req0_b = 16'h0008; ifb.req0_op = 2'b00;
      ifb.req0_valid = 1; ifb.rsp0_ready = 1;
      step();
      ifb.req0_valid = 0;
      step();
      #2;
      rst4_n = 0;
      #1;
      checks++; if ({ifb.busy, ifb.rsp0_valid, ifb.rsp1_valid} !== 3'b000) begin failures++; $display("FAIL mid_rst_state got=%b exp=000", {ifb.busy, ifb.rsp0_valid, ifb.rsp1_valid}); end
      checks++; if ({ifb.alu_a, ifb.alu_b, ifb.alu_sel, ifb.rsp_data} !== 50'd0) begin failures++; $display("FAIL mid_rst_regs got=%h/%h/%h/%h exp=0", ifb.alu_a, ifb.alu_b, ifb.alu_sel, ifb.rsp_data); end
      repeat (2) @(negedge clk);
      rst4_n = 1;
      repeat (10) begin
         step();
         if (ifb.rsp0_valid || ifb.rsp1_valid || ifb.busy) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL mid_rst_no_rsp got=%0d exp=0", bad); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_div0();
      test_round_robin();
      test_backpressure();
      test_exec4();
      test_reset_mid_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
